// File: rtl/switch_fabric_pkg.sv
// Shared AXI-Stream types and constants for the switch fabric.
// Each egress port has one round-robin arbiter state enum.
package switch_fabric_pkg;

  localparam int unsigned NUM_INGRESS_PORTS = 4;
  localparam int unsigned DATA_W            = 16;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic [1:0]        tdest;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_fabric_egress_arbiter.sv
// Per-egress round-robin arbiter: picks one requesting ingress lane,
// holds the grant for a whole packet and muxes that lane to the egress.
module egress_arbiter
  import switch_fabric_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = NUM_INGRESS_PORTS,
  localparam int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  axis_source_t         lane [NUM_PORTS],
  input  logic                 egress_tready,
  output axis_source_t         egress_source,
  output logic [IDX_W-1:0]     gnt,
  output logic                 locked
);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic             found;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!found && req[IDX_W'((32'(ptr) + k) % NUM_PORTS)]) begin
        found = 1'b1;
        pick  = IDX_W'((32'(ptr) + k) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= pick;
            ptr   <= IDX_W'((32'(pick) + 1) % NUM_PORTS);
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (egress_source.tvalid && egress_source.tlast && egress_tready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  always_comb begin
    egress_source = '0;
    if (state == LOCKED)
      egress_source = lane[gnt];
  end

endmodule

// File: rtl/switch_fabric.sv
// Packet-granular NxN AXI-Stream crossbar routing on tdest with one
// round-robin arbiter per egress port; no buffering in the data path.
module switch_fabric
  import switch_fabric_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_INGRESS_PORTS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  axis_d_source_t       ingress_source [NUM_PORTS],
  output axis_d_sink_t         ingress_sink   [NUM_PORTS],
  output axis_source_t         egress_source  [NUM_PORTS],
  input  axis_sink_t           egress_sink    [NUM_PORTS],
  output logic [NUM_PORTS-1:0] busy
);

  localparam int unsigned IDX_W = idx_width(NUM_PORTS);

  axis_source_t         lane [NUM_PORTS];
  logic [NUM_PORTS-1:0] req  [NUM_PORTS];
  logic [IDX_W-1:0]     gnt  [NUM_PORTS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      lane[i].tdata  = ingress_source[i].tdata;
      lane[i].tvalid = ingress_source[i].tvalid;
      lane[i].tlast  = ingress_source[i].tlast;
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = ingress_source[i].tvalid && (32'(ingress_source[i].tdest) == o);
      end
    end
  end

  // An ingress lane's tdest selects one egress, so at most one term is live.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      ingress_sink[i] = '0;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (busy[o] && (32'(gnt[o]) == i))
          ingress_sink[i].tready = ingress_sink[i].tready | egress_sink[o].tready;
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    egress_arbiter #(
      .NUM_PORTS (NUM_PORTS)
    ) u_arb (
      .clk           (clk),
      .reset         (reset),
      .req           (req[o]),
      .lane          (lane),
      .egress_tready (egress_sink[o].tready),
      .egress_source (egress_source[o]),
      .gnt           (gnt[o]),
      .locked        (busy[o])
    );
  end

endmodule

// File: tb/tb_switch_fabric.sv
// Self-checking bench for switch_fabric: directed scenarios plus random
// traffic compared against a packet-ownership reference model.
`timescale 1ns/1ps
module tb_switch_fabric;
  import switch_fabric_pkg::*;

  localparam int NP = NUM_INGRESS_PORTS;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset;
  axis_d_source_t ing_src [NP];
  axis_d_sink_t   ing_snk [NP];
  axis_source_t   eg_src  [NP];
  axis_sink_t     eg_snk  [NP];
  logic [NP-1:0]  busy;

  beat_t q [NP][$];
  bit    en     [NP];
  bit    eg_rdy [NP];
  int    own    [NP];   // ingress index owning each egress, -1 when free
  int    rr     [NP];   // next ingress to favour per egress
  int    n_cmp = 0;
  int    n_bad = 0;

  switch_fabric #(.NUM_PORTS(NP)) dut (
    .clk            (clk),
    .reset          (reset),
    .ingress_source (ing_src),
    .ingress_sink   (ing_snk),
    .egress_source  (eg_src),
    .egress_sink    (eg_snk),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      ing_src[i] = '0;
      if (en[i] && q[i].size() > 0) begin
        ing_src[i].tdata  = q[i][0].data;
        ing_src[i].tvalid = 1'b1;
        ing_src[i].tlast  = q[i][0].last;
        ing_src[i].tdest  = q[i][0].dest;
      end
      eg_snk[i].tready = eg_rdy[i];
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int o = 0; o < NP; o++) begin
        own[o] = -1;
        rr[o]  = 0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (own[o] < 0) begin
          for (int k = 0; k < NP; k++) begin
            int i;
            i = (rr[o] + k) % NP;
            if (own[o] < 0 && ing_src[i].tvalid && int'(ing_src[i].tdest) == o) begin
              own[o] = i;
              rr[o]  = (i + 1) % NP;
            end
          end
        end else if (ing_src[own[o]].tvalid && ing_src[own[o]].tlast && eg_snk[o].tready) begin
          own[o] = -1;
        end
      end
    end
  endtask

  // Called at a sample point; returns at the next sample point.
  task automatic advance();
    bit pop [NP];
    for (int i = 0; i < NP; i++) pop[i] = ing_src[i].tvalid && ing_snk[i].tready;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (pop[i]) void'(q[i].pop_front());
    drive();
    @(negedge clk);
  endtask

  task automatic push_beat(input int port, input logic [15:0] d, input bit last, input int dest);
    beat_t b;
    b.data = d;
    b.last = last;
    b.dest = 2'(dest);
    q[port].push_back(b);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NP; i++) begin
      q[i].delete();
      en[i]     = 1'b1;
      eg_rdy[i] = 1'b1;
    end
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push_beat(0, 16'h7777, 1'b1, 0);
    advance();
    advance();
    advance();
    for (int o = 0; o < NP; o++) begin
      n_cmp++;
      if (eg_src[o] !== '0) begin
        n_bad++;
        $display("FAIL reset_egress port=%0d got=%h exp=0", o, eg_src[o]);
      end
      n_cmp++;
      if (ing_snk[o].tready !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_tready port=%0d got=%b exp=0", o, ing_snk[o].tready);
      end
    end
    n_cmp++;
    if (busy !== '0) begin
      n_bad++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    for (int i = 0; i < NP; i++) q[i].delete();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [15:0]   ed [5] = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    bit            ev [5] = '{0, 1, 1, 1, 0};
    bit            el [5] = '{0, 0, 0, 1, 0};
    logic [NP-1:0] eb;
    do_reset();
    push_beat(0, 16'h1111, 1'b0, 2);
    push_beat(0, 16'h2222, 1'b0, 2);
    push_beat(0, 16'h3333, 1'b1, 2);
    for (int c = 0; c < 5; c++) begin
      advance();
      eb = ev[c] ? NP'(4) : NP'(0);
      n_cmp++;
      if (eg_src[2].tvalid !== ev[c] || eg_src[2].tdata !== ed[c] || eg_src[2].tlast !== el[c]) begin
        n_bad++;
        $display("FAIL single_eg2 cyc=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b",
                 c, eg_src[2].tvalid, eg_src[2].tdata, eg_src[2].tlast, ev[c], ed[c], el[c]);
      end
      n_cmp++;
      if (busy !== eb) begin
        n_bad++;
        $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, eb);
      end
      n_cmp++;
      if (ing_snk[0].tready !== ev[c]) begin
        n_bad++;
        $display("FAIL single_tready cyc=%0d got=%b exp=%b", c, ing_snk[0].tready, ev[c]);
      end
      n_cmp++;
      if ({eg_src[0].tvalid, eg_src[1].tvalid, eg_src[3].tvalid} !== 3'b000) begin
        n_bad++;
        $display("FAIL single_others cyc=%0d got=%b%b%b exp=000", c,
                 eg_src[0].tvalid, eg_src[1].tvalid, eg_src[3].tvalid);
      end
    end
  endtask

  task automatic test_contention();
    logic [15:0] ed [7] = '{16'h0, 16'hA000, 16'hA001, 16'h0, 16'hB000, 16'hB001, 16'h0};
    bit          ev [7] = '{0, 1, 1, 0, 1, 1, 0};
    bit          el [7] = '{0, 0, 1, 0, 0, 1, 0};
    bit          r0 [7] = '{0, 1, 1, 0, 0, 0, 0};
    bit          r1 [7] = '{0, 0, 0, 0, 1, 1, 0};
    do_reset();
    push_beat(0, 16'hA000, 1'b0, 1);
    push_beat(0, 16'hA001, 1'b1, 1);
    push_beat(1, 16'hB000, 1'b0, 1);
    push_beat(1, 16'hB001, 1'b1, 1);
    for (int c = 0; c < 7; c++) begin
      advance();
      n_cmp++;
      if (eg_src[1].tvalid !== ev[c] || eg_src[1].tdata !== ed[c] || eg_src[1].tlast !== el[c]) begin
        n_bad++;
        $display("FAIL contention_eg1 cyc=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b",
                 c, eg_src[1].tvalid, eg_src[1].tdata, eg_src[1].tlast, ev[c], ed[c], el[c]);
      end
      n_cmp++;
      if (ing_snk[0].tready !== r0[c] || ing_snk[1].tready !== r1[c]) begin
        n_bad++;
        $display("FAIL contention_tready cyc=%0d got=%b%b exp=%b%b",
                 c, ing_snk[0].tready, ing_snk[1].tready, r0[c], r1[c]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NP-1:0] got_r, exp_r;
    logic [15:0]   exp_d;
    bit            exp_v;
    int            k;
    do_reset();
    for (int s = 0; s < 3; s++)
      for (int p = 0; p < NP; p++) push_beat(p, 16'(p * 256 + s), 1'b1, 3);
    for (int c = 0; c < 25; c++) begin
      advance();
      exp_v = (c % 2) == 1;
      k     = (c - 1) / 2;
      exp_d = exp_v ? 16'((k % NP) * 256 + k / NP) : 16'h0;
      exp_r = exp_v ? (NP'(1) << (k % NP)) : '0;
      for (int i = 0; i < NP; i++) got_r[i] = ing_snk[i].tready;
      n_cmp++;
      if (eg_src[3].tvalid !== exp_v || eg_src[3].tdata !== exp_d || eg_src[3].tlast !== exp_v) begin
        n_bad++;
        $display("FAIL fairness_eg3 cyc=%0d got v=%b d=%h exp v=%b d=%h",
                 c, eg_src[3].tvalid, eg_src[3].tdata, exp_v, exp_d);
      end
      n_cmp++;
      if (got_r !== exp_r) begin
        n_bad++;
        $display("FAIL fairness_grant cyc=%0d got=%b exp=%b", c, got_r, exp_r);
      end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int c = 0;
    bit p;
    do_reset();
    for (int b = 0; b < 6; b++) push_beat(2, 16'(16'hC000 + b), b == 5, 0);
    advance();
    n_cmp++;
    if (ing_snk[2].tready !== 1'b0 || eg_src[0].tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_arb_cycle got rdy=%b v=%b exp rdy=0 v=0", ing_snk[2].tready, eg_src[0].tvalid);
    end
    while (k < 6 && c < 40) begin
      p         = (c % 4 == 0) || (c % 4 == 3);
      eg_rdy[0] = p;
      advance();
      n_cmp++;
      if (ing_snk[2].tready !== p) begin
        n_bad++;
        $display("FAIL bp_tready cyc=%0d got=%b exp=%b", c, ing_snk[2].tready, p);
      end
      n_cmp++;
      if (eg_src[0].tvalid !== 1'b1 || eg_src[0].tdata !== 16'(16'hC000 + k) || eg_src[0].tlast !== (k == 5)) begin
        n_bad++;
        $display("FAIL bp_beat cyc=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                 c, eg_src[0].tvalid, eg_src[0].tdata, eg_src[0].tlast, 16'(16'hC000 + k), k == 5);
      end
      if (p) k++;
      c++;
    end
    n_cmp++;
    if (k != 6) begin
      n_bad++;
      $display("FAIL bp_timeout got=%0d beats exp=6", k);
    end
    eg_rdy[0] = 1'b1;
    advance();
    n_cmp++;
    if (busy !== '0 || eg_src[0].tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got busy=%b v=%b exp busy=0 v=0", busy, eg_src[0].tvalid);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    for (int b = 0; b < 8; b++) begin
      push_beat(0, 16'(16'hD000 + b), b == 7, 1);
      push_beat(1, 16'(16'hE000 + b), b == 7, 0);
    end
    advance();
    for (int b = 0; b < 8; b++) begin
      advance();
      n_cmp++;
      if (eg_src[1].tvalid !== 1'b1 || eg_src[1].tdata !== 16'(16'hD000 + b) || eg_src[1].tlast !== (b == 7)) begin
        n_bad++;
        $display("FAIL parallel_eg1 beat=%0d got v=%b d=%h exp v=1 d=%h", b,
                 eg_src[1].tvalid, eg_src[1].tdata, 16'(16'hD000 + b));
      end
      n_cmp++;
      if (eg_src[0].tvalid !== 1'b1 || eg_src[0].tdata !== 16'(16'hE000 + b) || eg_src[0].tlast !== (b == 7)) begin
        n_bad++;
        $display("FAIL parallel_eg0 beat=%0d got v=%b d=%h exp v=1 d=%h", b,
                 eg_src[0].tvalid, eg_src[0].tdata, 16'(16'hE000 + b));
      end
      n_cmp++;
      if (busy !== NP'(3)) begin
        n_bad++;
        $display("FAIL parallel_busy beat=%0d got=%b exp=0011", b, busy);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int b = 0; b < 4; b++) push_beat(1, 16'(16'hF000 + b), b == 3, 0);
    advance();
    advance();
    advance();
    n_cmp++;
    if (eg_src[0].tvalid !== 1'b1 || eg_src[0].tdata !== 16'hF001) begin
      n_bad++;
      $display("FAIL midrst_beat2 got v=%b d=%h exp v=1 d=f001", eg_src[0].tvalid, eg_src[0].tdata);
    end
    reset = 1'b1;
    advance();
    for (int o = 0; o < NP; o++) begin
      n_cmp++;
      if (eg_src[o] !== '0 || ing_snk[o].tready !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_clear port=%0d got eg=%h rdy=%b exp eg=0 rdy=0", o, eg_src[o], ing_snk[o].tready);
      end
    end
    n_cmp++;
    if (busy !== '0) begin
      n_bad++;
      $display("FAIL midrst_busy got=%b exp=0", busy);
    end
    for (int i = 0; i < NP; i++) q[i].delete();
    advance();
    reset = 1'b0;
    push_beat(0, 16'h5A00, 1'b1, 0);
    push_beat(2, 16'h5A02, 1'b1, 0);
    advance();
    advance();
    n_cmp++;
    if (eg_src[0].tvalid !== 1'b1 || eg_src[0].tdata !== 16'h5A00) begin
      n_bad++;
      $display("FAIL midrst_fresh got v=%b d=%h exp v=1 d=5a00", eg_src[0].tvalid, eg_src[0].tdata);
    end
    n_cmp++;
    if (ing_snk[0].tready !== 1'b1 || ing_snk[2].tready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_fresh_rdy got=%b%b exp=10", ing_snk[0].tready, ing_snk[2].tready);
    end
  endtask

  task automatic test_random();
    axis_source_t exp_eg;
    bit           exp_r;
    int           len, dest;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int o = 0; o < NP; o++) begin
        exp_eg = '0;
        if (own[o] >= 0) begin
          exp_eg.tdata  = ing_src[own[o]].tdata;
          exp_eg.tvalid = ing_src[own[o]].tvalid;
          exp_eg.tlast  = ing_src[own[o]].tlast;
        end
        n_cmp++;
        if (eg_src[o] !== exp_eg) begin
          n_bad++;
          $display("FAIL rand_egress cyc=%0d port=%0d got=%h exp=%h", c, o, eg_src[o], exp_eg);
        end
        n_cmp++;
        if (busy[o] !== (own[o] >= 0)) begin
          n_bad++;
          $display("FAIL rand_busy cyc=%0d port=%0d got=%b exp=%b", c, o, busy[o], own[o] >= 0);
        end
      end
      for (int i = 0; i < NP; i++) begin
        exp_r = 1'b0;
        for (int o = 0; o < NP; o++) if (own[o] == i && eg_snk[o].tready) exp_r = 1'b1;
        n_cmp++;
        if (ing_snk[i].tready !== exp_r) begin
          n_bad++;
          $display("FAIL rand_tready cyc=%0d port=%0d got=%b exp=%b", c, i, ing_snk[i].tready, exp_r);
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len  = int'($urandom_range(1, 5));
          dest = int'($urandom_range(0, NP - 1));
          for (int b = 0; b < len; b++) push_beat(i, 16'($urandom), b == len - 1, dest);
        end
        en[i]     = $urandom_range(0, 4) != 0;
        eg_rdy[i] = $urandom_range(0, 3) != 0;
      end
      reset = ($urandom_range(0, 299) == 0);
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NP; i++) begin
      en[i]     = 1'b1;
      eg_rdy[i] = 1'b1;
      own[i]    = -1;
      rr[i]     = 0;
    end
    drive();
    @(negedge clk);
    test_reset();
    test_single_packet();
    test_contention();
    test_fairness();
    test_backpressure();
    test_parallel();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
